instn_fetch_unit: RTL
=====================

Name: instn_fetch_unit

Overview:
Instruction fetch stage that drives the read port of the word-addressed instruction block memory and supplies decode with a valid/ready stream of {pc, instruction}.
- Hides the memory's fixed 2-cycle read latency with an in-flight tracker and a small output FIFO.
- Issue is credit-based, so no fetched word is ever dropped under decode backpressure.
- Accepts PC redirects from execute (branch/jump) and squashes all stale fetches.

Parameters:
ADDR_WIDTH, 16, memory word-address width
DATA_WIDTH, 32, instruction width
PC_WIDTH, 32, byte-address PC width (must be >= ADDR_WIDTH+2)
RESET_PC, 0, byte PC loaded on reset (word aligned)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 4)

Ports:
clk  in  1  clock
rstn  in  1  reset
mem_rd_addr  out  ADDR_WIDTH  word address to instruction memory
mem_rd_data  in  DATA_WIDTH  memory read data, valid 2 cycles after address
redirect_valid  in  1  load redirect_pc and flush
redirect_pc  in  PC_WIDTH  new byte PC, bits [1:0] ignored
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_instn  out  DATA_WIDTH  head instruction
out_pc  out  PC_WIDTH  head byte PC
perf_fetched  out  32  accepted-instruction count (optional feature)
perf_stall  out  32  backpressure-cycle count (optional feature)

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While rstn=0: pc<=RESET_PC, in-flight valids<=0, FIFO empty, out_valid=0, out_instn=0, out_pc=0, perf counters<=0.
- mem_rd_addr = pc[ADDR_WIDTH+1:2], combinational from the pc register.
- Memory timing: address presented in cycle t returns data on mem_rd_data in cycle t+2.
- In-flight tracker: 2-stage shift register {valid, pc}, one stage per cycle of latency.
- Issue rule: issue=1 when fifo_count + inflight_count < FIFO_DEPTH and redirect_valid=0. Use current-cycle counts; a same-cycle dequeue does not add credit.
- On issue: stage0 <= {1, pc}, pc <= pc+4. Otherwise stage0.valid <= 0 and pc holds. pc wraps at 2^PC_WIDTH.
- Arrival: when stage1.valid=1, {stage1.pc, mem_rd_data} is written to the FIFO at the end of that cycle.
- Latency: issue in cycle t gives out_valid in cycle t+3. The FIFO has no bypass.
- Handshake: the head is dequeued when out_valid && out_ready. out_instn/out_pc hold stable while out_valid=1 and out_ready=0.
- Full throughput: with out_ready held at 1, one instruction per cycle in steady state (worst-case occupancy is 3 of 4).
- Overflow: the FIFO cannot overflow by construction. A write while full is an assertion failure in simulation.
- Redirect (cycle t):
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - Both in-flight valids cleared; data arriving in cycle t is discarded.
  - FIFO flushed, so out_valid=0 in cycle t+1.
  - No issue in cycle t. First new issue is in t+1; first new out_valid is in t+4.
- Simultaneous redirect and handshake: the handshake completes (decode took the head); the flush still applies.
- Back-to-back redirects: the last one wins; each one restarts the 3-cycle refill.
- Reset mid-operation: identical to the reset state. The memory's own registered data is ignored because the in-flight valids are 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every out_valid && out_ready.
  - perf_stall increments on every cycle with out_valid=1 and out_ready=0.
  - Both are 32-bit, wrap at 2^32, and are cleared only by reset, not by redirect.
- Undefined: both ports are present but tied to 0, and no counter logic is built.

Test Plan:
- Reset release, RESET_PC=0x0, mem[i]=i+0x100, out_ready=1 -> out_valid first in cycle 3 after rstn rises; stream pc 0x0,0x4,0x8… with instn 0x100,0x101,0x102…, one per cycle.
- out_ready=0 for 10 cycles after the first beat -> mem issue stops once fifo+inflight=4; release gives 0x0..0xC in order with no gap, loss, or duplicate.
- Redirect to 0x40 while 2 requests are in flight and the FIFO holds 2 -> out_valid=0 the next cycle; next output is pc 0x40 with instn mem[16], 4 cycles after the redirect; no stale pc appears.
- Redirect in the same cycle as a handshake of pc 0x8, then redirect_pc=0x23 -> 0x8 is counted accepted; next out_pc=0x20.
- Reset asserted mid-stream with a full FIFO -> out_valid=0 the next cycle; restart from RESET_PC matches scenario 1.
- With FETCH_PERF_CNT_EN: 20 accepts and 7 stall cycles -> perf_fetched=20, perf_stall=7; without the macro both read 0.

Source files
------------

// File: rtl/instn_fetch_unit.sv
// instn_fetch_unit: credit-based fetch over a 2-cycle instruction memory, feeding decode through a small FIFO.
// Define FETCH_PERF_CNT_EN to build the accepted/stall performance counters; otherwise they read 0.
module instn_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instn,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [PC_WIDTH-1:0] r_pc, r_s0_pc, r_s1_pc;
  logic r_s0_v, r_s1_v;
  logic [PC_WIDTH-1:0] r_fpc [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_finstn [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr, w_count;
  logic [AW+1:0] w_used;
  logic w_issue, w_wr, w_rd;
  // credit counts words already owed to the FIFO, so an issue never outruns free space
  assign w_count = r_wptr - r_rptr;
  assign w_used = {1'b0, w_count} + {{(AW+1){1'b0}}, r_s0_v} + {{(AW+1){1'b0}}, r_s1_v};
  assign w_issue = !redirect_valid && (w_used < (AW+2)'(FIFO_DEPTH));
  assign w_wr = r_s1_v && !redirect_valid;
  assign w_rd = out_valid && out_ready;
  assign mem_rd_addr = r_pc[ADDR_WIDTH+1:2];
  assign out_valid = w_count != '0;
  assign out_pc = out_valid ? r_fpc[r_rptr[AW-1:0]] : '0;
  assign out_instn = out_valid ? r_finstn[r_rptr[AW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc <= RESET_PC;
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_pc <= redirect_valid ? (redirect_pc & ~PC_WIDTH'(3)) : w_issue ? r_pc + PC_WIDTH'(4) : r_pc;
      r_s0_v <= w_issue;
      r_s1_v <= r_s0_v && !redirect_valid;
      r_wptr <= r_wptr + (AW+1)'(w_wr);
      r_rptr <= redirect_valid ? r_wptr : r_rptr + (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    r_s0_pc <= r_pc;
    r_s1_pc <= r_s0_pc;
    if (w_wr) begin
      r_fpc[r_wptr[AW-1:0]] <= r_s1_pc;
      r_finstn[r_wptr[AW-1:0]] <= mem_rd_data;
    end
  end
  always_ff @(posedge clk)
    if (rstn && w_wr) assert (w_count < (AW+1)'(FIFO_DEPTH));
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf_fetched <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_rd);
      r_perf_stall <= r_perf_stall + 32'(out_valid && !out_ready);
    end
  end
  assign perf_fetched = r_perf_fetched;
  assign perf_stall = r_perf_stall;
`else
  assign perf_fetched = '0;
  assign perf_stall = '0;
`endif
endmodule
